lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 7 +
 rtl/lfsr_checker_if.sv | 12 +
 rtl/lfsr_step.sv | 9 +
 rtl/lfsr_checker.sv | 102 ++++++++++
 tb/tb_lfsr_checker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared width, taps, seed and state encoding for the LFSR checker.
package lfsr_pkg;
  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] TAP_MASK = 16'hB400;
  localparam logic [WIDTH-1:0] SEED = 16'hACE1;
  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_e;
endpackage

// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: serial input stream and status outputs of the LFSR checker.
interface lfsr_checker_if;
  logic DIN;
  logic DIN_VALID;
  logic CLR_COUNT;
  logic LOCKED;
  logic ERR;
  logic [15:0] ERR_COUNT;
  logic [1:0] STATE;
  modport master(output DIN, DIN_VALID, CLR_COUNT, input LOCKED, ERR, ERR_COUNT, STATE);
  modport slave(input DIN, DIN_VALID, CLR_COUNT, output LOCKED, ERR, ERR_COUNT, STATE);
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: predicted next bit of x^16+x^14+x^13+x^11+1 from the reference register.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [WIDTH-1:0] r,
  output logic             p
);
  assign p = ^(r & TAP_MASK);
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires lock on a PRBS16 stream, then counts bit errors and tracks loss of lock.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT    = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input logic           CLK,
  input logic           RESET,
  lfsr_checker_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_q, win_d;
  logic [EW-1:0]    werr_q, werr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             locked_q, locked_d, err_q, err_d, p, mism;
  lfsr_step u_step (.r(r_q), .p(p));
  assign mism = bus.DIN ^ p;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    if (bus.DIN_VALID)
      case (state_q)
        SEARCH: begin
          r_d    = {r_q[WIDTH-2:0], bus.DIN};
          fill_d = fill_q + 1'b1;
          if (fill_d == FW'(WIDTH)) begin
            fill_d  = '0;
            match_d = '0;
            state_d = (r_d == '0) ? SEARCH : VERIFY;
          end
        end
        VERIFY: begin
          r_d     = {r_q[WIDTH-2:0], bus.DIN};
          fill_d  = '0;
          win_d   = '0;
          werr_d  = '0;
          match_d = mism ? '0 : match_q + 1'b1;
          state_d = mism ? SEARCH : (match_d == MW'(LOCK_CNT)) ? LOCK : VERIFY;
        end
        LOCK: begin
          // Shift the prediction, not DIN, so a channel error cannot corrupt R.
          r_d    = {r_q[WIDTH-2:0], p};
          err_d  = mism;
          werr_d = werr_q + EW'(mism);
          win_d  = win_q + 1'b1;
          if (werr_d == EW'(LOSS_THRESH)) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else if (win_d == WW'(WINDOW)) begin
            win_d  = '0;
            werr_d = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    cnt_d    = bus.CLR_COUNT ? {15'd0, err_d} : cnt_q + {15'd0, err_d && cnt_q != 16'hFFFF};
    locked_d = state_d == LOCK;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q  <= SEARCH;
      r_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  assign bus.LOCKED    = locked_q;
  assign bus.ERR       = err_q;
  assign bus.ERR_COUNT = cnt_q;
  assign bus.STATE     = state_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: random PRBS16 streams with injected errors against a bit-history reference model.
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lfsr_checker_if bus();
  lfsr_checker #(.LOCK_CNT(32), .WINDOW(64), .LOSS_THRESH(8)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  logic [15:0] g;
  int ms, fill, match, wpos, werr;
  bit hist[$];
  logic m_err, m_locked;
  logic [15:0] m_cnt;
  // Generator: each emitted bit obeys b[n] = b[n-16]^b[n-14]^b[n-13]^b[n-11].
  function automatic bit gen_bit();
    bit b = g[15] ^ g[13] ^ g[12] ^ g[10];
    g = {g[14:0], b};
    return b;
  endfunction
  // Reference: hist holds the last 16 reference bits, oldest at index 0.
  function automatic void model_step(bit r, bit v, bit d, bit c);
    bit p, nz;
    m_err = 1'b0;
    if (r) begin
      ms = 0; fill = 0; match = 0; wpos = 0; werr = 0; m_cnt = '0; m_locked = 1'b0;
      hist.delete();
      repeat (16) hist.push_back(1'b0);
      return;
    end
    if (v) begin
      p = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
      if (ms == 0) begin
        hist.push_back(d); void'(hist.pop_front());
        fill++;
        if (fill == 16) begin
          fill = 0; nz = 0;
          foreach (hist[i]) nz |= hist[i];
          if (nz) begin ms = 1; match = 0; end
        end
      end else if (ms == 1) begin
        hist.push_back(d); void'(hist.pop_front());
        if (d != p) begin ms = 0; fill = 0; end
        else begin
          match++;
          if (match == 32) begin ms = 2; wpos = 0; werr = 0; end
        end
      end else begin
        hist.push_back(p); void'(hist.pop_front());
        if (d != p) begin m_err = 1'b1; werr++; end
        wpos++;
        if (werr == 8) begin ms = 0; fill = 0; end
        else if (wpos == 64) begin wpos = 0; werr = 0; end
      end
    end
    if (c) m_cnt = {15'd0, m_err};
    else if (m_err && m_cnt != 16'hFFFF) m_cnt++;
    m_locked = (ms == 2);
  endfunction
  task automatic cyc(input bit r, input bit v, input bit d, input bit c);
    @(negedge clk);
    rst = r; bus.DIN_VALID = v; bus.DIN = d; bus.CLR_COUNT = c;
    @(posedge clk);
    model_step(r, v, d, c);
    #1;
  endtask
  task automatic send(input bit flip, input bit clr);
    cyc(1'b0, 1'b1, gen_bit() ^ flip, clr);
  endtask
  task automatic gaps();
    repeat ($urandom_range(3)) cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
  endtask
  task automatic reset_and_lock(output int nb);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    g  = 16'hACE1;
    nb = 0;
    for (int i = 0; i < 200 && bus.LOCKED !== 1'b1; i++) begin send(1'b0, 1'b0); nb++; end
  endtask
  task automatic test_reset();
    cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b/%b/%h/%0d want 0/0/0000/0", bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE);
    end
  endtask
  task automatic test_acquire();
    int nb;
    reset_and_lock(nb);
    n_vec++;
    if (nb != 48) begin n_bad++; $display("FAIL lock_latency: got %0d bits want 48", nb); end
    for (int i = 0; i < 9952; i++) begin
      send(1'b0, 1'b0);
      n_vec++;
      if ({bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE} !== {m_locked, m_err, m_cnt, 2'(ms)}) begin
        n_bad++;
        $display("FAIL clean_stream bit %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d", i, bus.LOCKED, bus.ERR,
                 bus.ERR_COUNT, bus.STATE, m_locked, m_err, m_cnt, ms);
      end
    end
    n_vec++;
    if (bus.ERR_COUNT !== 16'h0 || bus.LOCKED !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_10000: got count %h locked %b want 0000 1", bus.ERR_COUNT, bus.LOCKED);
    end
  endtask
  task automatic test_single_error();
    int pulses = 0, drops = 0;
    repeat ($urandom_range(5, 20)) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    n_vec++;
    if (bus.ERR !== 1'b1 || bus.ERR_COUNT !== 16'd1 || bus.LOCKED !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err_pulse: got err %b count %h locked %b want 1 0001 1", bus.ERR, bus.ERR_COUNT, bus.LOCKED);
    end
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0);
      pulses += int'(bus.ERR);
      drops += int'(!bus.LOCKED);
    end
    n_vec++;
    if (pulses != 0 || drops != 0 || bus.ERR_COUNT !== 16'd1) begin
      n_bad++;
      $display("FAIL single_err_after: got pulses %0d drops %0d count %h want 0 0 0001", pulses, drops, bus.ERR_COUNT);
    end
  endtask
  task automatic test_loss();
    int nb, k = 0;
    int pos[8];
    foreach (pos[j]) pos[j] = j * 7 + int'($urandom_range(6));
    reset_and_lock(nb);
    for (int i = 0; i < 64 && k < 8; i++) begin
      send(i == pos[k], 1'b0);
      if (i == pos[k]) k++;
      n_vec++;
      if (bus.LOCKED !== m_locked || bus.ERR !== m_err) begin
        n_bad++;
        $display("FAIL loss_trace bit %0d: got locked %b err %b want %b %b", i, bus.LOCKED, bus.ERR, m_locked, m_err);
      end
    end
    n_vec++;
    if (bus.LOCKED !== 1'b0 || bus.ERR_COUNT !== 16'd8 || bus.STATE !== 2'd0) begin
      n_bad++;
      $display("FAIL loss_8th: got locked %b count %h state %0d want 0 0008 0", bus.LOCKED, bus.ERR_COUNT, bus.STATE);
    end
    nb = 0;
    for (int i = 0; i < 200 && bus.LOCKED !== 1'b1; i++) begin send(1'b0, 1'b0); nb++; end
    n_vec++;
    if (nb != 48 || bus.ERR_COUNT !== 16'd8) begin
      n_bad++;
      $display("FAIL relock: got %0d bits count %h want 48 0008", nb, bus.ERR_COUNT);
    end
  endtask
  task automatic test_window_boundary();
    int nb, k;
    int pos[7];
    foreach (pos[j]) pos[j] = j * 9 + int'($urandom_range(8));
    reset_and_lock(nb);
    k = 0;
    for (int i = 0; i < 64; i++) begin
      send((k < 7 && i == pos[k]) || i == 63, 1'b0);
      if (k < 7 && i == pos[k]) k++;
    end
    n_vec++;
    if (bus.LOCKED !== 1'b0 || bus.ERR !== 1'b1 || bus.ERR_COUNT !== 16'd8) begin
      n_bad++;
      $display("FAIL wrap_priority: got locked %b err %b count %h want 0 1 0008", bus.LOCKED, bus.ERR, bus.ERR_COUNT);
    end
    reset_and_lock(nb);
    k = 0;
    for (int i = 0; i < 128; i++) begin
      send((k < 7 && i == pos[k]) || i == 64 + pos[0], 1'b0);
      if (k < 7 && i == pos[k]) k++;
    end
    n_vec++;
    if (bus.LOCKED !== 1'b1 || bus.ERR_COUNT !== 16'd8) begin
      n_bad++;
      $display("FAIL window_clear: got locked %b count %h want 1 0008", bus.LOCKED, bus.ERR_COUNT);
    end
  endtask
  task automatic test_zero_stream();
    int bad = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if ({bus.LOCKED, bus.ERR, bus.STATE} !== 4'h0 || ms != 0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_bad++; $display("FAIL zero_stream: got %0d bad cycles want 0", bad); end
  endtask
  task automatic test_verify_mismatch();
    int nb;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    g = 16'hACE1;
    repeat (16) send(1'b0, 1'b0);
    n_vec++;
    if (bus.STATE !== 2'd1) begin n_bad++; $display("FAIL verify_entry: got state %0d want 1", bus.STATE); end
    repeat (19) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    n_vec++;
    if (bus.STATE !== 2'd0 || bus.ERR !== 1'b0 || bus.ERR_COUNT !== 16'd0 || bus.LOCKED !== 1'b0) begin
      n_bad++;
      $display("FAIL verify_mismatch: got state %0d err %b count %h locked %b want 0 0 0000 0", bus.STATE, bus.ERR,
               bus.ERR_COUNT, bus.LOCKED);
    end
    nb = 0;
    for (int i = 0; i < 200 && bus.LOCKED !== 1'b1; i++) begin send(1'b0, 1'b0); nb++; end
    n_vec++;
    if (nb != 48) begin n_bad++; $display("FAIL verify_relock: got %0d bits want 48", nb); end
  endtask
  task automatic test_random_valid();
    int nb = 0;
    bit v;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    g = 16'hACE1;
    for (int i = 0; i < 2000 && bus.LOCKED !== 1'b1; i++) begin
      v = 1'($urandom_range(1));
      cyc(1'b0, v, v ? gen_bit() : 1'($urandom_range(1)), 1'b0);
      nb += int'(v);
      n_vec++;
      if ({bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE} !== {m_locked, m_err, m_cnt, 2'(ms)}) begin
        n_bad++;
        $display("FAIL sparse_trace cycle %0d: got %b/%b/%h/%0d want %b/%b/%h/%0d", i, bus.LOCKED, bus.ERR,
                 bus.ERR_COUNT, bus.STATE, m_locked, m_err, m_cnt, ms);
      end
    end
    n_vec++;
    if (nb != 48) begin n_bad++; $display("FAIL sparse_lock: got %0d valid bits want 48", nb); end
    gaps(); send(1'b1, 1'b0); gaps(); send(1'b1, 1'b0); gaps();
    n_vec++;
    if (bus.ERR !== 1'b0 || bus.ERR_COUNT !== m_cnt || m_cnt != 16'd2) begin
      n_bad++;
      $display("FAIL sparse_errors: got err %b count %h want 0 0002", bus.ERR, bus.ERR_COUNT);
    end
    send(1'b1, 1'b1);
    n_vec++;
    if (bus.ERR !== 1'b1 || bus.ERR_COUNT !== 16'd1) begin
      n_bad++;
      $display("FAIL clr_with_err: got err %b count %h want 1 0001", bus.ERR, bus.ERR_COUNT);
    end
    gaps(); send(1'b0, 1'b1);
    n_vec++;
    if (bus.ERR_COUNT !== 16'd0 || bus.LOCKED !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_alone: got count %h locked %b want 0000 1", bus.ERR_COUNT, bus.LOCKED);
    end
    send(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'($urandom_range(1)), 1'b1);
    n_vec++;
    if ({bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_mid_lock: got %b/%b/%h/%0d want 0/0/0000/0", bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.STATE);
    end
  endtask
  initial begin
    bus.DIN = 1'b0; bus.DIN_VALID = 1'b0; bus.CLR_COUNT = 1'b0;
    test_reset();
    test_acquire();
    test_single_error();
    test_loss();
    test_window_boundary();
    test_zero_stream();
    test_verify_mismatch();
    test_random_valid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
